// File: rtl/sumador_cla4.sv
// 4-bit carry-lookahead group: sum, carry-out and group generate/propagate.
// Purely combinational, zero latency, no flow control.
module sumador_cla4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_s,
   output logic       o_cout,
   output logic       o_g,
   output logic       o_p
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [4:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Every carry is expanded directly from cin, so none waits on a lower bit.
   assign w_c[0] = i_cin;
   assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_cin);

   assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign o_p = &w_p;

   assign w_c[4] = o_g | (o_p & i_cin);

   assign o_s    = w_p ^ w_c[3:0];
   assign o_cout = w_c[4];

endmodule

// File: rtl/sumador.sv
// Unsigned WIDTH-bit adder, carry-extended WIDTH+1 result registered one cycle later.
// One result per cycle, no handshake and no stall; async active-low reset clears sum/out_valid.
module sumador #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   sum,
   output logic             out_valid
);

   localparam int NGRP = WIDTH / 4;

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
         $error("sumador: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   logic [NGRP:0]    w_carry;
   logic [WIDTH-1:0] w_sum_lo;
   logic [NGRP-1:0]  w_grp_g;
   logic [NGRP-1:0]  w_grp_p;
   logic [WIDTH:0]   w_next_sum;
   logic             w_unused_gp;

   logic [WIDTH:0]   r_sum;
   logic             r_valid;

   assign w_carry[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < NGRP; gi++) begin : g_grp
         sumador_cla4 u_cla4 (
            .i_a    (a[4*gi +: 4]),
            .i_b    (b[4*gi +: 4]),
            .i_cin  (w_carry[gi]),
            .o_s    (w_sum_lo[4*gi +: 4]),
            .o_cout (w_carry[gi+1]),
            .o_g    (w_grp_g[gi]),
            .o_p    (w_grp_p[gi])
         );
      end
   endgenerate

   // Group G/P are available for a second-level lookahead; the ripple chain does not need them.
   assign w_unused_gp = ^{w_grp_g, w_grp_p};

   assign w_next_sum = {w_carry[NGRP], w_sum_lo};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_sum   <= w_next_sum;
         r_valid <= 1'b1;
      end
   end

   assign sum       = r_sum;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_sumador.sv
// Self-checking bench for sumador at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random).
module tb_sumador;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic [4:0] sum;
   logic       out_valid;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic [8:0] sum8;
   logic       out_valid8;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   sumador #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .sum       (sum),
      .out_valid (out_valid)
   );

   sumador #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a8),
      .b         (b8),
      .sum       (sum8),
      .out_valid (out_valid8)
   );

   // Reference: exact unsigned sum computed with plain integer arithmetic.
   function automatic int ref_add(input int x, input int y);
      return x + y;
   endfunction

   task automatic apply_and_check(input string name, input int x, input int y);
      int e;
      @(negedge clk);
      a = 4'(x);
      b = 4'(y);
      e = ref_add(x, y);
      @(posedge clk);
      #1;
      vec_cnt++;
      if (sum !== 5'(e) || out_valid !== 1'b1) begin
         err_cnt++;
         $display("FAIL %s: %0d+%0d got sum=%0d valid=%b, want sum=%0d valid=1",
                  name, x, y, sum, out_valid, e);
      end
   endtask

   task automatic test_reset;
      a = 4'hF; b = 4'hF; a8 = 8'hFF; b8 = 8'hFF;
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (sum !== 5'd0 || out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_async: got sum=%0d valid=%b, want 0/0", sum, out_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if (sum !== 5'd0 || out_valid !== 1'b0 || sum8 !== 9'd0 || out_valid8 !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_clocked: got sum=%0d valid=%b sum8=%0d valid8=%b, want all 0",
                  sum, out_valid, sum8, out_valid8);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      apply_and_check("basic_2p3", 2, 3);
      apply_and_check("carry_12p10", 12, 10);
   endtask

   task automatic test_extremes;
      apply_and_check("max_15p15", 15, 15);
      apply_and_check("zero_0p0", 0, 0);
      apply_and_check("ripple_15p1", 15, 1);
   endtask

   task automatic test_back_to_back;
      int xs[3] = '{3, 7, 8};
      int ys[3] = '{4, 9, 8};
      int exp_q[$];
      int e;
      @(negedge clk);
      a = 4'(xs[0]); b = 4'(ys[0]);
      exp_q.push_back(ref_add(xs[0], ys[0]));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         vec_cnt++;
         if (sum !== 5'(e) || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_%0d: got sum=%0d valid=%b, want sum=%0d valid=1",
                     i, sum, out_valid, e);
         end
         // Change inputs mid-cycle: the registered sum must hold until the next edge.
         if (i < 2) begin
            a = 4'(xs[i+1]); b = 4'(ys[i+1]);
            exp_q.push_back(ref_add(xs[i+1], ys[i+1]));
         end else begin
            a = 4'd1; b = 4'd1;
         end
         #2;
         vec_cnt++;
         if (sum !== 5'(e)) begin
            err_cnt++;
            $display("FAIL b2b_hold_%0d: got sum=%0d, want sum=%0d", i, sum, e);
         end
      end
   endtask

   task automatic test_mid_reset;
      apply_and_check("pre_reset_9p9", 9, 9);
      @(negedge clk);
      a = 4'd5; b = 4'd6;
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (sum !== 5'd0 || out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL midreset_async: got sum=%0d valid=%b, want 0/0", sum, out_valid);
      end
      @(posedge clk);
      #1;
      vec_cnt++;
      if (sum !== 5'd0 || out_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL midreset_hold: got sum=%0d valid=%b, want 0/0", sum, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vec_cnt++;
      if (sum !== 5'(ref_add(5, 6)) || out_valid !== 1'b1) begin
         err_cnt++;
         $display("FAIL midreset_release: got sum=%0d valid=%b, want sum=11 valid=1",
                  sum, out_valid);
      end
   endtask

   task automatic test_exhaustive;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            apply_and_check("sweep", x, y);
         end
      end
   endtask

   task automatic test_random_w8;
      int x;
      int y;
      int e;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         x = (n == 0) ? 255 : int'($urandom_range(0, 255));
         y = (n == 0) ? 255 : int'($urandom_range(0, 255));
         a8 = 8'(x);
         b8 = 8'(y);
         e = ref_add(x, y);
         @(posedge clk);
         #1;
         vec_cnt++;
         if (sum8 !== 9'(e) || out_valid8 !== 1'b1) begin
            err_cnt++;
            $display("FAIL w8_rand: %0d+%0d got sum=%0d valid=%b, want sum=%0d valid=1",
                     x, y, sum8, out_valid8, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_extremes();
      test_back_to_back();
      test_mid_reset();
      test_exhaustive();
      test_random_w8();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
